// File: rtl/io_map_pkg.sv
// Shared I/O map for the timer responder: base address, register offsets and CTRL bit positions.
// Also holds the address-window helpers used by the bus decode.
package io_map_pkg;

    localparam logic [15:0] IO_TIMER_BASE = 16'h1000;

    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_PRESC = 3'd1;
    localparam logic [2:0] OFF_CMP_L = 3'd2;
    localparam logic [2:0] OFF_CMP_H = 3'd3;
    localparam logic [2:0] OFF_CNT_L = 3'd4;
    localparam logic [2:0] OFF_CNT_H = 3'd5;
    localparam logic [2:0] OFF_STAT  = 3'd6;
    localparam logic [2:0] OFF_RSVD  = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_AUTOCLR = 2;
    localparam int CTRL_ONESHOT = 3;

    // True when addr falls in the 8-byte window starting at base.
    function automatic logic in_block(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] off;
        off = addr - base;
        return (off < 16'd8);
    endfunction

    // Register offset of addr within the window starting at base.
    function automatic logic [2:0] reg_offset(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] off;
        off = addr - base;
        return off[2:0];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts 0..div while enabled and pulses tick on the terminal count.
// clr restarts the count from 0; en low freezes it.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] presc_cnt_r;
    logic       at_top_s;

    assign at_top_s = (presc_cnt_r == div);
    assign tick     = en && at_top_s;

    // Prescale counter with synchronous reset and bus-triggered restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt_r <= 8'd0;
        end else if (clr) begin
            presc_cnt_r <= 8'd0;
        end else if (en) begin
            presc_cnt_r <= at_top_s ? 8'd0 : presc_cnt_r + 8'd1;
        end else begin
            presc_cnt_r <= presc_cnt_r;
        end
    end

endmodule

// File: rtl/io_timer_responder.sv
// Memory-mapped 16-bit timer responder: prescaler, counter, compare and match flag/irq.
// Reads are registered (1-cycle latency); CNT_H returns the high byte captured by the last CNT_L read.
module io_timer_responder
    import io_map_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = IO_TIMER_BASE,
    parameter logic [15:0] RST_CMP   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic [15:0] w_addr,
    input  logic        w_en,
    input  logic [15:0] r_addr,
    input  logic        r_en,
    output logic [7:0]  dout,
    output logic        hit,
    output logic        irq,
    input  logic        irq_ack
);

    logic [3:0]  ctrl_r;
    logic [7:0]  presc_r;
    logic [15:0] cmp_r;
    logic [15:0] cnt_r;
    logic [7:0]  cnt_shadow_r;
    logic        flag_r;
    logic [7:0]  dout_r;
    logic        hit_r;

    logic        w_in_s;
    logic [2:0]  w_off_s;
    logic        r_in_s;
    logic [2:0]  r_off_s;
    logic        wr_ctrl_s, wr_presc_s, wr_cmp_l_s, wr_cmp_h_s;
    logic        wr_cnt_l_s, wr_cnt_h_s, wr_stat_s;
    logic        tick_s;
    logic        match_s;
    logic [7:0]  rd_data_s;

    assign w_in_s  = w_en && in_block(w_addr, BASE_ADDR);
    assign w_off_s = reg_offset(w_addr, BASE_ADDR);
    assign r_in_s  = r_en && in_block(r_addr, BASE_ADDR);
    assign r_off_s = reg_offset(r_addr, BASE_ADDR);
    assign match_s = (cnt_r == cmp_r);

    // Write strobe decode, one strobe per register.
    always_comb begin
        wr_ctrl_s  = 1'b0;
        wr_presc_s = 1'b0;
        wr_cmp_l_s = 1'b0;
        wr_cmp_h_s = 1'b0;
        wr_cnt_l_s = 1'b0;
        wr_cnt_h_s = 1'b0;
        wr_stat_s  = 1'b0;
        if (w_in_s) begin
            case (w_off_s)
                OFF_CTRL:  wr_ctrl_s  = 1'b1;
                OFF_PRESC: wr_presc_s = 1'b1;
                OFF_CMP_L: wr_cmp_l_s = 1'b1;
                OFF_CMP_H: wr_cmp_h_s = 1'b1;
                OFF_CNT_L: wr_cnt_l_s = 1'b1;
                OFF_CNT_H: wr_cnt_h_s = 1'b1;
                OFF_STAT:  wr_stat_s  = 1'b1;
                default:   wr_stat_s  = 1'b0;
            endcase
        end else begin
            wr_stat_s = 1'b0;
        end
    end

    // Read data mux; uses pre-write register values so a same-cycle write is not visible.
    always_comb begin
        rd_data_s = 8'd0;
        case (r_off_s)
            OFF_CTRL:  rd_data_s = {4'd0, ctrl_r};
            OFF_PRESC: rd_data_s = presc_r;
            OFF_CMP_L: rd_data_s = cmp_r[7:0];
            OFF_CMP_H: rd_data_s = cmp_r[15:8];
            OFF_CNT_L: rd_data_s = cnt_r[7:0];
            OFF_CNT_H: rd_data_s = cnt_shadow_r;
            OFF_STAT:  rd_data_s = {7'd0, flag_r};
            default:   rd_data_s = 8'd0;
        endcase
    end

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_r[CTRL_EN]),
        .clr   (wr_ctrl_s || wr_presc_s),
        .div   (presc_r),
        .tick  (tick_s)
    );

    // Register file, counter, match flag and registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_r       <= 4'd0;
            presc_r      <= 8'd0;
            cmp_r        <= RST_CMP;
            cnt_r        <= 16'd0;
            cnt_shadow_r <= 8'd0;
            flag_r       <= 1'b0;
            dout_r       <= 8'd0;
            hit_r        <= 1'b0;
        end else begin
            // A bus write to CTRL overrides the one-shot auto-disable.
            if (wr_ctrl_s) begin
                ctrl_r <= din[3:0];
            end else if (tick_s && match_s && ctrl_r[CTRL_ONESHOT]) begin
                ctrl_r[CTRL_EN] <= 1'b0;
            end else begin
                ctrl_r <= ctrl_r;
            end

            if (wr_presc_s) presc_r <= din;
            else            presc_r <= presc_r;

            if (wr_cmp_l_s)      cmp_r[7:0]  <= din;
            else if (wr_cmp_h_s) cmp_r[15:8] <= din;
            else                 cmp_r       <= cmp_r;

            // A bus byte write suppresses the increment entirely.
            if (wr_cnt_l_s) begin
                cnt_r[7:0] <= din;
            end else if (wr_cnt_h_s) begin
                cnt_r[15:8] <= din;
            end else if (tick_s) begin
                cnt_r <= (match_s && ctrl_r[CTRL_AUTOCLR]) ? 16'd0 : cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (tick_s && match_s) begin
                flag_r <= 1'b1;
            end else if (irq_ack || (wr_stat_s && din[0])) begin
                flag_r <= 1'b0;
            end else begin
                flag_r <= flag_r;
            end

            if (r_in_s) begin
                dout_r <= rd_data_s;
                hit_r  <= 1'b1;
                if (r_off_s == OFF_CNT_L) cnt_shadow_r <= cnt_r[15:8];
                else                      cnt_shadow_r <= cnt_shadow_r;
            end else begin
                dout_r <= 8'd0;
                hit_r  <= 1'b0;
            end
        end
    end

    assign dout = dout_r;
    assign hit  = hit_r;
    assign irq  = flag_r && ctrl_r[CTRL_IRQ_EN];

endmodule

// File: tb/tb_io_timer_responder.sv
// Directed bench for io_timer_responder: a register read/write vector table plus
// hand-written sequences for prescaled matches, one-shot, atomic count reads, irq and reset.
module tb_io_timer_responder;

    localparam logic [15:0] BASE = 16'h1000;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic [15:0] w_addr;
    logic        w_en;
    logic [15:0] r_addr;
    logic        r_en;
    logic [7:0]  dout;
    logic        hit;
    logic        irq;
    logic        irq_ack;

    int checks;
    int errors;

    io_timer_responder #(.BASE_ADDR(16'h1000), .RST_CMP(16'hFFFF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .w_addr  (w_addr),
        .w_en    (w_en),
        .r_addr  (r_addr),
        .r_en    (r_en),
        .dout    (dout),
        .hit     (hit),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [7:0]  exp_dout;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        w_addr = addr;
        din    = data;
        w_en   = 1'b1;
        step(1);
        w_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] exp_d, input logic exp_h, input string name);
        r_addr = addr;
        r_en   = 1'b1;
        step(1);
        r_en   = 1'b0;
        chk({name, ".dout"}, {8'd0, dout}, {8'd0, exp_d});
        chk({name, ".hit"}, {15'd0, hit}, {15'd0, exp_h});
    endtask

    // Write one register and read another (or the same) in the same cycle.
    task automatic wrrd(input logic [15:0] waddr, input logic [7:0] data, input logic [15:0] raddr,
                        input logic [7:0] exp_d, input string name);
        w_addr = waddr;
        din    = data;
        w_en   = 1'b1;
        r_addr = raddr;
        r_en   = 1'b1;
        step(1);
        w_en   = 1'b0;
        r_en   = 1'b0;
        chk({name, ".dout"}, {8'd0, dout}, {8'd0, exp_d});
        chk({name, ".hit"}, {15'd0, hit}, 16'd1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        din     = 8'd0;
        w_addr  = 16'd0;
        w_en    = 1'b0;
        r_addr  = 16'd0;
        r_en    = 1'b0;
        irq_ack = 1'b0;

        vecs[0]  = '{16'h1000, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{16'h1001, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{16'h1002, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[3]  = '{16'h1003, 1'b0, 8'h00, 8'hFF, 1'b1};
        vecs[4]  = '{16'h1004, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{16'h1005, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{16'h1006, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{16'h1007, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{16'h1008, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{16'h0FFF, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{16'h1000, 1'b1, 8'hF0, 8'h00, 1'b1};
        vecs[11] = '{16'h1001, 1'b1, 8'hA5, 8'hA5, 1'b1};
        vecs[12] = '{16'h1002, 1'b1, 8'h34, 8'h34, 1'b1};
        vecs[13] = '{16'h1003, 1'b1, 8'h12, 8'h12, 1'b1};
        vecs[14] = '{16'h1004, 1'b1, 8'h78, 8'h78, 1'b1};
        vecs[15] = '{16'h1006, 1'b1, 8'hFE, 8'h00, 1'b1};
        vecs[16] = '{16'h1007, 1'b1, 8'hFF, 8'h00, 1'b1};
        vecs[17] = '{16'h1008, 1'b1, 8'h55, 8'h00, 1'b0};

        // Reset state and register map
        step(1);
        do_reset();
        chk("rst.dout", {8'd0, dout}, 16'h0000);
        chk("rst.hit", {15'd0, hit}, 16'd0);
        chk("rst.irq", {15'd0, irq}, 16'd0);
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp_dout, vecs[i].exp_hit, $sformatf("vec%0d", i));
        end
        // CNT_H reads the shadow captured by the CNT_L read (0x00), not the raw byte
        wr(BASE + 16'd5, 8'h56);
        rd(BASE + 16'd5, 8'h00, 1'b1, "cnth_shadow_old");
        rd(BASE + 16'd4, 8'h78, 1'b1, "cntl_latch");
        rd(BASE + 16'd5, 8'h56, 1'b1, "cnth_shadow_new");
        wrrd(BASE + 16'd1, 8'h11, BASE + 16'd1, 8'hA5, "same_cycle_wr_rd");
        rd(BASE + 16'd1, 8'h11, 1'b1, "presc_after_wr");

        // Prescaled autoclear match: PRESC=3, CMP=4 -> period 20
        do_reset();
        wr(BASE + 16'd1, 8'h03);
        wr(BASE + 16'd2, 8'h04);
        wr(BASE + 16'd3, 8'h00);
        wr(BASE + 16'd0, 8'h07);
        step(19);
        chk("t2.irq_c19", {15'd0, irq}, 16'd0);
        step(1);
        chk("t2.irq_c20", {15'd0, irq}, 16'd1);
        rd(BASE + 16'd6, 8'h01, 1'b1, "t2.stat");
        rd(BASE + 16'd4, 8'h00, 1'b1, "t2.cnt_cleared");
        wr(BASE + 16'd6, 8'h01);
        step(16);
        chk("t2.irq_c39", {15'd0, irq}, 16'd0);
        step(1);
        chk("t2.irq_c40", {15'd0, irq}, 16'd1);

        // One-shot: CMP=2, PRESC=0
        do_reset();
        wr(BASE + 16'd2, 8'h02);
        wr(BASE + 16'd3, 8'h00);
        wr(BASE + 16'd1, 8'h00);
        wr(BASE + 16'd0, 8'h09);
        step(4);
        rd(BASE + 16'd0, 8'h08, 1'b1, "t3.ctrl_en_off");
        rd(BASE + 16'd4, 8'h03, 1'b1, "t3.cnt_l");
        rd(BASE + 16'd5, 8'h00, 1'b1, "t3.cnt_h");
        rd(BASE + 16'd6, 8'h01, 1'b1, "t3.flag");
        chk("t3.irq_masked", {15'd0, irq}, 16'd0);
        step(5);
        rd(BASE + 16'd4, 8'h03, 1'b1, "t3.cnt_hold");

        // Atomic CNT read across the 0x00FF -> 0x0100 carry
        do_reset();
        wr(BASE + 16'd4, 8'hFF);
        wr(BASE + 16'd5, 8'h00);
        wrrd(BASE + 16'd0, 8'h01, BASE + 16'd4, 8'hFF, "t4.cnt_l_ff");
        rd(BASE + 16'd5, 8'h00, 1'b1, "t4.cnt_h_snap");
        rd(BASE + 16'd4, 8'h00, 1'b1, "t4.cnt_l_next");
        rd(BASE + 16'd5, 8'h01, 1'b1, "t4.cnt_h_next");

        // irq_ack colliding with a match, then flag clear paths
        do_reset();
        wr(BASE + 16'd2, 8'h03);
        wr(BASE + 16'd3, 8'h00);
        wr(BASE + 16'd0, 8'h03);
        step(3);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        chk("t5.set_wins", {15'd0, irq}, 16'd1);
        wr(BASE + 16'd6, 8'h00);
        chk("t5.stat_wr0", {15'd0, irq}, 16'd1);
        wr(BASE + 16'd0, 8'h01);
        chk("t5.irq_en_off", {15'd0, irq}, 16'd0);
        rd(BASE + 16'd6, 8'h01, 1'b1, "t5.flag_kept");
        wr(BASE + 16'd0, 8'h03);
        chk("t5.irq_en_on", {15'd0, irq}, 16'd1);
        wr(BASE + 16'd6, 8'h01);
        chk("t5.stat_wr1", {15'd0, irq}, 16'd0);
        rd(BASE + 16'd6, 8'h00, 1'b1, "t5.flag_clr");

        // Reset mid-count with irq asserted and a read in flight
        do_reset();
        wr(BASE + 16'd2, 8'h05);
        wr(BASE + 16'd3, 8'h00);
        wr(BASE + 16'd0, 8'h07);
        step(8);
        chk("t6.irq_pre", {15'd0, irq}, 16'd1);
        rst_n  = 1'b0;
        r_addr = BASE;
        r_en   = 1'b1;
        step(1);
        r_en   = 1'b0;
        rst_n  = 1'b1;
        chk("t6.dout", {8'd0, dout}, 16'h0000);
        chk("t6.hit", {15'd0, hit}, 16'd0);
        chk("t6.irq", {15'd0, irq}, 16'd0);
        step(3);
        for (int i = 0; i < 8; i++) begin
            rd(vecs[i].addr, vecs[i].exp_dout, vecs[i].exp_hit, $sformatf("t6.reg%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
